// File: rtl/sram_phase_ctrl_pkg.sv
// Shared codes for the SRAM phase sequencer and the clock divider.
// Gray phase codes, reset level, FSM encodings and width defaults.
package sram_phase_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b0;

    localparam logic [1:0] PH_ONE   = 2'b00;
    localparam logic [1:0] PH_TWO   = 2'b01;
    localparam logic [1:0] PH_THREE = 2'b11;
    localparam logic [1:0] PH_FOUR  = 2'b10;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_STROBE = 2'b10,
        ST_HOLD   = 2'b11
    } state_e;

    // Divider phase each state must observe at its edge.
    function automatic logic [1:0] exp_phase(input state_e s);
        logic [1:0] ph;
        ph = PH_ONE;
        unique case (s)
            ST_IDLE:   ph = PH_ONE;
            ST_SETUP:  ph = PH_TWO;
            ST_STROBE: ph = PH_THREE;
            ST_HOLD:   ph = PH_FOUR;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/sram_phase_ctrl.sv
// One SRAM read or write per slow period, sequenced by divider phase.
// Strobes are registered; a phase-sequence break aborts and sets err.
module sram_phase_ctrl
    import sram_phase_ctrl_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        phase,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_o,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              err
);

    state_e            state_q;
    state_e            state_d;
    logic              is_wr_q;
    logic              is_wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_o_d;
    logic              data_oe_d;
    logic              ce_n_d;
    logic              oe_n_d;
    logic              we_n_d;
    logic [DATA_W-1:0] rdata_d;
    logic              rvalid_d;
    logic              busy_d;
    logic              err_d;
    logic              phase_bad;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_IDLE;
            is_wr_q     <= 1'b0;
            ram_addr    <= '0;
            ram_data_o  <= '0;
            ram_data_oe <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            ram_addr    <= addr_d;
            ram_data_o  <= data_o_d;
            ram_data_oe <= data_oe_d;
            ram_ce_n    <= ce_n_d;
            ram_oe_n    <= oe_n_d;
            ram_we_n    <= we_n_d;
            rdata       <= rdata_d;
            rdata_valid <= rvalid_d;
            busy        <= busy_d;
            err         <= err_d;
        end
    end

    // IDLE never checks phase; it only waits for PH_ONE.
    assign phase_bad = (state_q != ST_IDLE)
                    && (phase != exp_phase(state_q));

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        addr_d    = ram_addr;
        data_o_d  = ram_data_o;
        data_oe_d = ram_data_oe;
        ce_n_d    = ram_ce_n;
        oe_n_d    = ram_oe_n;
        we_n_d    = ram_we_n;
        rdata_d   = rdata;
        rvalid_d  = rdata_valid;
        busy_d    = busy;
        err_d     = err;

        if (phase_bad) begin
            ce_n_d    = 1'b1;
            oe_n_d    = 1'b1;
            we_n_d    = 1'b1;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            rvalid_d  = 1'b0;
            err_d     = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req && (phase == PH_ONE)) begin
                        is_wr_d  = we;
                        addr_d   = addr;
                        data_o_d = wdata;
                        ce_n_d   = 1'b0;
                        busy_d   = 1'b1;
                        rvalid_d = 1'b0;
                        state_d  = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (is_wr_q) begin
                        data_oe_d = 1'b1;
                        we_n_d    = 1'b0;
                    end else begin
                        oe_n_d = 1'b0;
                    end
                    state_d = ST_STROBE;
                end
                ST_STROBE: begin
                    // Write data stays driven one more cycle for hold.
                    if (is_wr_q) begin
                        we_n_d = 1'b1;
                    end else begin
                        rdata_d = ram_data_i;
                        oe_n_d  = 1'b1;
                    end
                    state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    ce_n_d    = 1'b1;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b0;
                    rvalid_d  = !is_wr_q;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_phase_ctrl.sv
// Scoreboard bench for sram_phase_ctrl with a behavioural SRAM.
// Completions are checked by a monitor against queued expectations.
module tb_sram_phase_ctrl;
    import sram_phase_ctrl_pkg::*;

    typedef struct {
        logic [15:0] rdata;
        logic        valid;
        logic        err;
        int          oe;
        int          we;
        logic [17:0] addr;
        logic [15:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  phase;
    logic        req;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] ram_data_i;
    logic [17:0] ram_addr;
    logic [15:0] ram_data_o;
    logic        ram_data_oe;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        busy;
    logic        err;

    logic [1:0]  gcnt = 2'b00;
    logic        ph_force;
    logic [1:0]  ph_val;
    logic [15:0] mem [logic [17:0]];
    exp_t        sb [$];
    int          vectors = 0;
    int          miscompares = 0;

    sram_phase_ctrl dut (
        .clk(clk), .rst(rst), .phase(phase), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .ram_data_i(ram_data_i),
        .ram_addr(ram_addr), .ram_data_o(ram_data_o),
        .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n),
        .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] gray_next(input logic [1:0] g);
        case (g)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clk) gcnt <= gray_next(gcnt);
    assign phase = ph_force ? ph_val : gcnt;

    always @(*) begin
        ram_data_i = 16'h0000;
        if (ram_ce_n === 1'b0 && ram_oe_n === 1'b0 && mem.exists(ram_addr))
            ram_data_i = mem[ram_addr];
    end

    always @(posedge ram_we_n)
        if (ram_ce_n === 1'b0 && ram_data_oe === 1'b1)
            mem[ram_addr] = ram_data_o;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] rd, input logic v,
                                input logic e, input int oe, input int w,
                                input logic [17:0] a, input logic [15:0] wd);
        exp_t x;
        x.rdata = rd; x.valid = v; x.err = e;
        x.oe = oe; x.we = w; x.addr = a; x.wd = wd;
        return x;
    endfunction

    // Monitor: gathers strobe activity per access, checks on busy fall.
    logic        prev_busy = 1'b0;
    int          s_oe = 0;
    int          s_we = 0;
    logic [17:0] s_addr = '0;
    logic [15:0] s_wd = '0;

    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            if (ram_oe_n === 1'b0) s_oe++;
            if (ram_we_n === 1'b0) begin
                s_we++;
                s_wd = ram_data_o;
            end
            s_addr = ram_addr;
        end
        if (ram_we_n === 1'b0 && ram_oe_n === 1'b0) begin
            miscompares++;
            $display("FAIL we_oe_overlap: both strobes low");
        end
        if (ram_data_oe === 1'b1 && ram_oe_n === 1'b0) begin
            miscompares++;
            $display("FAIL bus_contention: data_oe with oe_n low");
        end
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty: completion with no expectation");
            end else begin
                e = sb.pop_front();
                chk("rdata", 32'(rdata), 32'(e.rdata));
                chk("rdata_valid", 32'(rdata_valid), 32'(e.valid));
                chk("err", 32'(err), 32'(e.err));
                chk("oe_low_cycles", s_oe, e.oe);
                chk("we_low_cycles", s_we, e.we);
                chk("ram_addr", 32'(s_addr), 32'(e.addr));
                chk("wr_data", 32'(s_wd), 32'(e.wd));
                chk("done_ce_n", 32'(ram_ce_n), 32'd1);
                chk("done_data_oe", 32'(ram_data_oe), 32'd0);
            end
            s_oe = 0; s_we = 0; s_addr = '0; s_wd = '0;
        end
        prev_busy = busy;
    end

    task automatic wait_gray(input logic [1:0] g);
        int n = 0;
        while (gcnt != g && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (gcnt != g) begin
            miscompares++;
            $display("FAIL phase_sync: got %0h expected %0h", gcnt, g);
        end
    endtask

    task automatic do_access(input logic w, input logic [17:0] a,
                             input logic [15:0] d, input exp_t e);
        wait_gray(PH_ONE);
        req = 1'b1; we = w; addr = a; wdata = d;
        sb.push_back(e);
        @(negedge clk);
        chk("accept_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        ph_force = 1'b0; ph_val = 2'b00;
        mem[18'h00123] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_ce_n", 32'(ram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
        chk("rst_we_n", 32'(ram_we_n), 32'd1);
        chk("rst_data_oe", 32'(ram_data_oe), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_data_o", 32'(ram_data_o), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_valid", 32'(rdata_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;

        // Read then write, back to back.
        do_access(1'b0, 18'h00123, 16'h0000,
                  mk(16'hBEEF, 1'b1, 1'b0, 1, 0, 18'h00123, 16'h0));
        do_access(1'b1, 18'h3FFFF, 16'h5A5A,
                  mk(16'hBEEF, 1'b0, 1'b0, 0, 1, 18'h3FFFF, 16'h5A5A));
        req = 1'b0;
        chk("mem_3ffff", 32'(mem[18'h3FFFF]), 32'h5A5A);

        // Request raised at phase 11 waits for the next 00.
        wait_gray(PH_THREE);
        req = 1'b1; we = 1'b0; addr = 18'h00123;
        sb.push_back(mk(16'hBEEF, 1'b1, 1'b0, 1, 0, 18'h00123, 16'h0));
        @(negedge clk);
        chk("align_idle_11", 32'(ram_ce_n), 32'd1);
        @(negedge clk);
        chk("align_idle_10", 32'(ram_ce_n), 32'd1);
        @(negedge clk);
        chk("align_accept", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);

        // Write then read the same word with no idle gap.
        do_access(1'b1, 18'd5, 16'h0001,
                  mk(16'hBEEF, 1'b0, 1'b0, 0, 1, 18'd5, 16'h0001));
        do_access(1'b0, 18'd5, 16'h0000,
                  mk(16'h0001, 1'b1, 1'b0, 1, 0, 18'd5, 16'h0));
        req = 1'b0;

        // Phase forced to 00 during STROBE aborts the read.
        wait_gray(PH_ONE);
        req = 1'b1; we = 1'b0; addr = 18'h00123;
        sb.push_back(mk(16'h0001, 1'b0, 1'b1, 1, 0, 18'h00123, 16'h0));
        @(negedge clk);
        @(negedge clk);
        ph_force = 1'b1; ph_val = 2'b00;
        @(negedge clk);
        ph_force = 1'b0;
        req = 1'b0;
        chk("brk_oe_n", 32'(ram_oe_n), 32'd1);
        chk("brk_ce_n", 32'(ram_ce_n), 32'd1);
        chk("brk_we_n", 32'(ram_we_n), 32'd1);
        chk("brk_err", 32'(err), 32'd1);
        chk("brk_rdata", 32'(rdata), 32'h0001);

        // err stays set across a good access.
        do_access(1'b0, 18'd5, 16'h0000,
                  mk(16'h0001, 1'b1, 1'b1, 1, 0, 18'd5, 16'h0));
        req = 1'b0;

        // Reset while the write strobe is low.
        wait_gray(PH_ONE);
        req = 1'b1; we = 1'b1; addr = 18'd7; wdata = 16'h1234;
        sb.push_back(mk(16'h0000, 1'b0, 1'b0, 0, 1, 18'd7, 16'h1234));
        @(negedge clk);
        @(negedge clk);
        chk("mid_we_n_low", 32'(ram_we_n), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_we_n", 32'(ram_we_n), 32'd1);
        chk("mr_ce_n", 32'(ram_ce_n), 32'd1);
        chk("mr_data_oe", 32'(ram_data_oe), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        rst = 1'b1;
        req = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d expectations left", sb.size());
        end
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
